// File: rtl/mic_frame_collector_pkg.sv
// Shared constants, output word layout and the output FSM state type
// for the microphone frame collector.
package mic_pkg;

    localparam int DW       = 24;
    localparam int WORD_W   = 32;

    // Output word field positions
    localparam int MISS_BIT = 31;
    localparam int CH_LSB   = 28;
    localparam int SEQ_LSB  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_e;

    // Add a small increment to a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/mic_frame_collector_if.sv
// Valid/ready word stream carrying assembled microphone frames.
interface mic_stream_if;

    logic [mic_pkg::WORD_W-1:0] M_DATA;
    logic                       M_VALID;
    logic                       M_READY;
    logic                       M_LAST;

    modport master (output M_DATA, M_VALID, M_LAST, input M_READY);
    modport slave  (input M_DATA, M_VALID, M_LAST, output M_READY);

endinterface

// File: rtl/mic_frame_collector_en_sync_edge.sv
// Brings one receiver's frame-ready level into the CLK domain and
// produces a single-cycle pulse on its rising edge.
module en_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], en_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/mic_frame_collector.sv
// Collects one sample per microphone per WS frame, assembles a frame
// when every channel has reported (or a timeout expires) and streams
// it out one 32-bit word per channel.
module mic_frame_collector #(
    parameter int N_MIC       = 4,
    parameter int DW          = 24,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_MIC*DW-1:0]   SDATA_IN,
    input  logic [N_MIC-1:0]      EN_IN,
    mic_stream_if.master          m,
    output logic [15:0]           OVERRUN_CNT
);

    import mic_pkg::*;

    localparam logic [15:0] TLAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_CH = 3'(N_MIC - 1);

    logic [N_MIC-1:0] rise;
    logic [DW-1:0]    hold_q [N_MIC];
    logic [N_MIC-1:0] pend_q, pend_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic [15:0]      ovr_q, ovr_d;
    logic [3:0]       ovr_inc;
    logic [DW-1:0]    obuf_q [N_MIC];
    logic [N_MIC-1:0] miss_q;
    logic [3:0]       seq_q, seq_l_q;
    logic [2:0]       ch_q, ch_d;
    out_state_e       st_q, st_d;
    logic             launch;
    logic [DW-1:0]    sample;
    logic             miss;

    for (genvar k = 0; k < N_MIC; k++) begin : g_sync
        en_sync_edge u_sync (
            .clk_i  (CLK),
            .rst_i  (RST),
            .en_i   (EN_IN[k]),
            .rise_o (rise[k])
        );
    end

    // A frame is ready when all channels reported or the timeout ran out;
    // it can only be taken while the output side is idle.
    assign launch = (st_q == IDLE) && (pend_q != '0) &&
                    ((&pend_q) || (tcnt_q == TLAST));

    // Pending bits, overrun accounting and timeout counter next state.
    // An edge in the launch cycle starts the next frame and is not an overrun.
    always_comb begin
        pend_d  = pend_q;
        ovr_inc = '0;
        if (launch) pend_d = '0;
        for (int k = 0; k < N_MIC; k++) begin
            if (rise[k]) begin
                pend_d[k] = 1'b1;
                if (pend_q[k] && !launch) ovr_inc = ovr_inc + 4'd1;
            end
        end
        ovr_d  = sat_add16(ovr_q, ovr_inc);
        tcnt_d = tcnt_q;
        if (launch || (pend_q == '0)) tcnt_d = '0;
        else if (tcnt_q != TLAST)     tcnt_d = tcnt_q + 16'd1;
    end

    // Capture registers: latest sample per channel plus frame bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_MIC; k++) hold_q[k] <= '0;
            pend_q <= '0;
            tcnt_q <= '0;
            ovr_q  <= '0;
        end else begin
            for (int k = 0; k < N_MIC; k++) begin
                if (rise[k]) hold_q[k] <= SDATA_IN[k*DW +: DW];
            end
            pend_q <= pend_d;
            tcnt_q <= tcnt_d;
            ovr_q  <= ovr_d;
        end
    end

    // Snapshot the held samples into the output buffer on launch;
    // channels that never reported are flagged and sent as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_MIC; k++) obuf_q[k] <= '0;
            miss_q  <= '0;
            seq_q   <= '0;
            seq_l_q <= '0;
        end else if (launch) begin
            for (int k = 0; k < N_MIC; k++) obuf_q[k] <= pend_q[k] ? hold_q[k] : '0;
            miss_q  <= ~pend_q;
            seq_l_q <= seq_q;
            seq_q   <= seq_q + 4'd1;
        end
    end

    // Output FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q <= IDLE;
            ch_q <= '0;
        end else begin
            st_q <= st_d;
            ch_q <= ch_d;
        end
    end

    // Output FSM next state: walk the channels, advancing on each handshake
    always_comb begin
        st_d = st_q;
        ch_d = ch_q;
        case (st_q)
            IDLE: begin
                if (launch) begin
                    st_d = SEND;
                    ch_d = '0;
                end
            end
            SEND: begin
                if (m.M_READY) begin
                    if (ch_q == LAST_CH) begin
                        st_d = IDLE;
                        ch_d = '0;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Output word assembly; everything reads zero outside SEND
    always_comb begin
        sample = '0;
        miss   = 1'b0;
        for (int k = 0; k < N_MIC; k++) begin
            if (ch_q == 3'(k)) begin
                sample = obuf_q[k];
                miss   = miss_q[k];
            end
        end
        m.M_DATA  = '0;
        m.M_VALID = (st_q == SEND);
        m.M_LAST  = (st_q == SEND) && (ch_q == LAST_CH);
        if (st_q == SEND) begin
            m.M_DATA[MISS_BIT]     = miss;
            m.M_DATA[CH_LSB +: 3]  = ch_q;
            m.M_DATA[SEQ_LSB +: 4] = seq_l_q;
            m.M_DATA[DW-1:0]       = sample;
        end
    end

    assign OVERRUN_CNT = ovr_q;

endmodule

// File: tb/tb_mic_frame_collector.sv
// Directed bench for mic_frame_collector with a frame-level scoreboard.
module tb_mic_frame_collector;

    localparam int N_MIC       = 4;
    localparam int DW          = 24;
    localparam int TIMEOUT_CYC = 256;

    logic                CLK = 1'b0;
    logic                RST;
    logic [N_MIC*DW-1:0] SDATA_IN;
    logic [N_MIC-1:0]    EN_IN;
    logic [15:0]         OVERRUN_CNT;

    mic_stream_if m ();

    mic_frame_collector #(
        .N_MIC       (N_MIC),
        .DW          (DW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SDATA_IN    (SDATA_IN),
        .EN_IN       (EN_IN),
        .m           (m),
        .OVERRUN_CNT (OVERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests_run = 0;
    int fails     = 0;

    logic [32:0] exp_q [$];   // {last, word}
    logic [31:0] got_q [$];
    int          seq_m = 0;
    int          ovr_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected frame: one word per channel, missing channels flagged with
    // a zero sample, sequence number advancing mod 16 per frame.
    function automatic void push_frame(input logic [23:0] s0, input logic [23:0] s1,
                                       input logic [23:0] s2, input logic [23:0] s3,
                                       input logic [3:0] present);
        logic [23:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < N_MIC; k++) begin
            logic [31:0] w;
            w = {~present[k], 3'(k), 4'(seq_m), present[k] ? s[k] : 24'h0};
            exp_q.push_back({(k == N_MIC - 1), w});
        end
        seq_m = (seq_m + 1) % 16;
    endfunction

    // Compare process: every accepted word against the scoreboard, and
    // every stalled cycle against the previous one.
    initial begin
        logic [32:0] e;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'd0, m.M_VALID}, 32'd1);
                    check("stall_data", m.M_DATA, prev_data);
                    check("stall_last", {31'd0, m.M_LAST}, {31'd0, prev_last});
                end
                if (m.M_VALID && m.M_READY) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        fails++;
                        $display("FAIL extra_word: got %h expected no word", m.M_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", m.M_DATA, e[31:0]);
                        check("last", {31'd0, m.M_LAST}, {31'd0, e[32]});
                    end
                    got_q.push_back(m.M_DATA);
                end
                prev_stall = m.M_VALID && !m.M_READY;
                prev_data  = m.M_DATA;
                prev_last  = m.M_LAST;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic rise(input int k, input logic [23:0] s);
        SDATA_IN[k*DW +: DW] = s;
        EN_IN[k] = 1'b1;
    endtask

    task automatic drop_all();
        EN_IN = '0;
        tick(4);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m.M_VALID) && n < 2000) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || m.M_VALID) begin
            fails++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m.M_VALID && n < 50) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (!m.M_VALID) begin
            fails++;
            $display("FAIL %s_valid: M_VALID=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic do_reset();
        EN_IN = '0;
        RST   = 1'b1;
        exp_q.delete();
        seq_m = 0;
        ovr_m = 0;
        tick(3);
        RST = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        RST       = 1'b1;
        EN_IN     = '0;
        SDATA_IN  = '0;
        m.M_READY = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, m.M_VALID}, 32'd0);
        check("rst_data", m.M_DATA, 32'd0);
        check("rst_last", {31'd0, m.M_LAST}, 32'd0);
        check("rst_ovr", {16'd0, OVERRUN_CNT}, 32'd0);
        RST = 1'b0;
        tick(2);
        m.M_READY = 1'b1;

        // Full frame, channels reporting on consecutive cycles
        got_q.delete();
        rise(0, 24'h000001); tick(1);
        rise(1, 24'h000002); tick(1);
        rise(2, 24'h000003); tick(1);
        rise(3, 24'h000004);
        push_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004, 4'hF);
        wait_drain("t1");
        check("t1_count", got_q.size(), 32'd4);
        check("t1_w0", got_q[0], 32'h00000001);
        check("t1_w1", got_q[1], 32'h10000002);
        check("t1_w2", got_q[2], 32'h20000003);
        check("t1_w3", got_q[3], 32'h30000004);
        drop_all();

        // Back-pressure: 50 stalled cycles mid-frame
        got_q.delete();
        m.M_READY = 1'b0;
        for (int k = 0; k < N_MIC; k++) rise(k, 24'h5A0000 + 24'(k));
        push_frame(24'h5A0000, 24'h5A0001, 24'h5A0002, 24'h5A0003, 4'hF);
        wait_valid("t3");
        tick(50);
        check("t3_valid_held", {31'd0, m.M_VALID}, 32'd1);
        m.M_READY = 1'b1;
        wait_drain("t3");
        check("t3_count", got_q.size(), 32'd4);
        check("t3_seq", {28'd0, got_q[0][27:24]}, 32'd1);
        drop_all();

        // Channel 0 reports twice before the frame completes
        got_q.delete();
        rise(0, 24'h111111); tick(3);
        EN_IN[0] = 1'b0; tick(4);
        rise(0, 24'h222222); ovr_m++; tick(4);
        check("t4_ovr_lit", {16'd0, OVERRUN_CNT}, 32'd1);
        rise(1, 24'h333333); rise(2, 24'h444444); rise(3, 24'h555555);
        push_frame(24'h222222, 24'h333333, 24'h444444, 24'h555555, 4'hF);
        wait_drain("t4");
        check("t4_w0", got_q[0], 32'h02222222);
        check("t4_ovr", {16'd0, OVERRUN_CNT}, 32'(ovr_m));
        drop_all();

        // Channel 1 re-reports in exactly the launch cycle
        got_q.delete();
        rise(0, 24'h0A0A0A); rise(1, 24'h1B1B1B); rise(3, 24'h3D3D3D); tick(4);
        EN_IN[1] = 1'b0; tick(4);
        rise(2, 24'h2C2C2C); tick(1);
        rise(1, 24'h1E1E1E);
        push_frame(24'h0A0A0A, 24'h1B1B1B, 24'h2C2C2C, 24'h3D3D3D, 4'hF);
        tick(6);
        EN_IN[0] = 1'b0; EN_IN[2] = 1'b0; EN_IN[3] = 1'b0; tick(4);
        rise(0, 24'h0F0F0F); rise(2, 24'h2F2F2F); rise(3, 24'h3F3F3F);
        push_frame(24'h0F0F0F, 24'h1E1E1E, 24'h2F2F2F, 24'h3F3F3F, 4'hF);
        wait_drain("t5");
        check("t5_count", got_q.size(), 32'd8);
        check("t5_old_ch1", got_q[1], 32'h131B1B1B);
        check("t5_new_ch1", got_q[5], 32'h141E1E1E);
        check("t5_ovr", {16'd0, OVERRUN_CNT}, 32'(ovr_m));
        drop_all();

        // Reset while word 1 waits on a stalled sink
        got_q.delete();
        m.M_READY = 1'b0;
        for (int k = 0; k < N_MIC; k++) rise(k, 24'h600000 + 24'(k));
        push_frame(24'h600000, 24'h600001, 24'h600002, 24'h600003, 4'hF);
        wait_valid("t6");
        m.M_READY = 1'b1;
        tick(1);
        m.M_READY = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("t6_valid", {31'd0, m.M_VALID}, 32'd0);
        check("t6_data", m.M_DATA, 32'd0);
        check("t6_last", {31'd0, m.M_LAST}, 32'd0);
        check("t6_ovr", {16'd0, OVERRUN_CNT}, 32'd0);
        EN_IN = '0;
        exp_q.delete();
        seq_m = 0;
        ovr_m = 0;
        tick(3);
        RST = 1'b0;
        tick(2);
        check("t6_words_before_rst", got_q.size(), 32'd1);
        got_q.delete();
        m.M_READY = 1'b1;
        for (int k = 0; k < N_MIC; k++) rise(k, 24'h700000 + 24'(k));
        push_frame(24'h700000, 24'h700001, 24'h700002, 24'h700003, 4'hF);
        wait_drain("t6b");
        check("t6b_w0", got_q[0], 32'h00700000);
        drop_all();

        // Channel 2 never reports: frame forced out by the timeout
        do_reset();
        m.M_READY = 1'b1;
        got_q.delete();
        c0 = cyc;
        rise(0, 24'hABCDEF); rise(1, 24'hABCDEF); rise(3, 24'hABCDEF);
        push_frame(24'hABCDEF, 24'hABCDEF, 24'h0, 24'hABCDEF, 4'b1011);
        n = 0;
        while (!m.M_VALID && n < 400) begin
            @(negedge CLK);
            n++;
        end
        // pend lands 3 edges after the drive, launch is decided TIMEOUT_CYC-1
        // cycles later and M_VALID shows after the launch edge.
        check("t2_launch_cycle", 32'(cyc - c0), 32'(3 + TIMEOUT_CYC));
        wait_drain("t2");
        check("t2_w0", got_q[0], 32'h00ABCDEF);
        check("t2_w2", got_q[2], 32'hA0000000);
        check("t2_w3", got_q[3], 32'h30ABCDEF);
        drop_all();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
